// File: rtl/present_key_scheduler_pkg.sv
// Shared PRESENT key-schedule definitions: S-box, round-key sizing and FSM state type.
// Used by the scheduler top level and by the reusable one-round update block.
package present_pkg;

    localparam int RK_W           = 64;
    localparam int NUM_ROUND_KEYS = 32;

    localparam logic [3:0] PRESENT_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic {
        KS_IDLE,
        KS_RUN
    } ks_state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] nibble);
        return PRESENT_SBOX[nibble];
    endfunction

endpackage

// File: rtl/present_key_scheduler_ks_round.sv
// One PRESENT key-register update (rotate, S-box, counter XOR), purely combinational.
// Shared between the key scheduler and the cipher's on-the-fly decrypt path.
module present_ks_round
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] key_cur,
    input  logic [4:0]       counter,
    output logic [KEY_W-1:0] key_next
);

    logic [KEY_W-1:0] rotated;

    // Rotate left by 61 == move the low KEY_W-61 bits to the top.
    assign rotated = {key_cur[KEY_W-62:0], key_cur[KEY_W-1:KEY_W-61]};

    if (KEY_W == 128) begin : g_k128
        always_comb begin
            key_next          = rotated;
            key_next[127:124] = sbox4(rotated[127:124]);
            key_next[123:120] = sbox4(rotated[123:120]);
            key_next[66:62]   = rotated[66:62] ^ counter;
        end
    end else begin : g_k80
        always_comb begin
            key_next                = rotated;
            key_next[KEY_W-1 -: 4]  = sbox4(rotated[KEY_W-1 -: 4]);
            key_next[19:15]         = rotated[19:15] ^ counter;
        end
    end

endmodule

// File: rtl/present_key_scheduler.sv
// Sequential PRESENT key scheduler: loads a master key and streams K1..K32 over
// a valid/ready interface so the cipher core can consume round keys at its own pace.
module present_key_scheduler
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int NUM_RK = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_in,
    input  logic             start,
    output logic             busy,
    output logic [RK_W-1:0]  rk_out,
    output logic [5:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             done
);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_key_scheduler: KEY_W must be 80 or 128");
    end
    if (NUM_RK != NUM_ROUND_KEYS) begin : g_bad_num_rk
        $error("present_key_scheduler: NUM_RK must be 32");
    end

    ks_state_t        state;
    ks_state_t        next_state;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] key_upd;
    logic [5:0]       idx_reg;
    logic             done_reg;
    logic             load;
    logic             advance;
    logic             finish;

    present_ks_round #(
        .KEY_W (KEY_W)
    ) u_round (
        .key_cur  (key_reg),
        .counter  (idx_reg[4:0]),
        .key_next (key_upd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= KS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake on the last key closes the schedule instead of updating the key.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            KS_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = KS_RUN;
                end
            end
            KS_RUN: begin
                if (rk_ready) begin
                    if (idx_reg == 6'(NUM_RK)) begin
                        finish     = 1'b1;
                        next_state = KS_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_reg  <= '0;
            idx_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= finish;
            if (load) begin
                key_reg <= key_in;
                idx_reg <= 6'd1;
            end else if (advance) begin
                key_reg <= key_upd;
                idx_reg <= idx_reg + 6'd1;
            end
        end
    end

    assign busy     = (state == KS_RUN);
    assign rk_valid = (state == KS_RUN);
    assign rk_out   = key_reg[KEY_W-1 -: RK_W];
    assign rk_idx   = idx_reg;
    assign done     = done_reg;

endmodule
